orbit_index_ctrl: RTL and testbench

//  Upstream of the per-ball motion stage. Turns the raw keyboard keycode into a rate-limited rotation strobe.

---
 rtl/orbit_index_ctrl.sv | 164 ++++++++++++++++
 tb/tb_orbit_index_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/orbit_index_ctrl.sv
// orbit_index_ctrl
// Turns the raw keyboard keycode into a rate-limited rotation strobe. It owns
// the shared angular index of the red/blue ball pair. Blue always sits HALF
// steps away from red.
//
// Ports
//   frame_clk    in   1  frame clock, one edge per video frame
//   Reset        in   1  synchronous active-high reset
//   keycode      in   8  raw keycode from the keyboard interface
//   red_dead     in   1  red ball eliminated (level)
//   blue_dead    in   1  blue ball eliminated (level)
//   rot_keycode  out  8  KEY_CW/KEY_CCW for one cycle per step, else 0
//   red_index    out  6  red angular index (pre-step while rot_keycode != 0)
//   blue_index   out  6  (red_index + HALF) mod N_POS
//   halted       out  1  both balls dead, rotation frozen until Reset
module orbit_index_ctrl #(
    parameter int unsigned N_POS        = 60,
    parameter int unsigned HALF         = 30,
    parameter int unsigned REPEAT_DELAY = 8,
    parameter int unsigned REPEAT_RATE  = 2,
    parameter logic [7:0]  KEY_CW       = 8'h07,
    parameter logic [7:0]  KEY_CCW      = 8'h04
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       red_dead,
    input  logic       blue_dead,
    output logic [7:0] rot_keycode,
    output logic [5:0] red_index,
    output logic [5:0] blue_index,
    output logic       halted
);

    localparam int unsigned IDX_W   = 6;
    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT,
        ST_HALT
    } state_t;

    state_t             r_state;
    logic [7:0]         r_rot_keycode;
    logic [IDX_W-1:0]   r_red_index;
    logic [IDX_W-1:0]   r_blue_index;
    logic               r_halted;
    logic               r_pend;
    logic               r_dir_cw;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_is_cw;
    logic               w_is_ccw;
    logic               w_dir_key;
    logic               w_same_dir;
    logic               w_step_cw;
    logic [IDX_W-1:0]   w_red_next;
    logic [IDX_W-1:0]   w_blue_next;

    // Key decode: only the two rotation keys count as "a key"
    assign w_is_cw    = (keycode == KEY_CW);
    assign w_is_ccw   = (keycode == KEY_CCW);
    assign w_dir_key  = w_is_cw | w_is_ccw;
    assign w_same_dir = (w_is_cw & r_dir_cw) | (w_is_ccw & ~r_dir_cw);

    // Direction of the in-flight step comes from the strobe itself
    assign w_step_cw  = (r_rot_keycode == KEY_CW);

    // Wrap-around stepping; never produces a value outside 0..N_POS-1
    always_comb begin
        w_red_next = r_red_index;
        if (w_step_cw) begin
            if (r_red_index == '0)
                w_red_next = IDX_W'(N_POS - 1);
            else
                w_red_next = r_red_index - IDX_W'(1);
        end else begin
            if (r_red_index == IDX_W'(N_POS - 1))
                w_red_next = '0;
            else
                w_red_next = r_red_index + IDX_W'(1);
        end
    end

    // Blue derived from the new red value
    assign w_blue_next = (w_red_next >= IDX_W'(HALF)) ? (w_red_next - IDX_W'(HALF))
                                                      : (w_red_next + IDX_W'(HALF));

    // Control FSM, step issue and pending index update
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_rot_keycode <= '0;
            r_red_index   <= '0;
            r_blue_index  <= IDX_W'(HALF);
            r_halted      <= 1'b0;
            r_pend        <= 1'b0;
            r_dir_cw      <= 1'b0;
            r_cnt         <= '0;
        end else begin
            // Second half of a step: commit the index, drop the strobe
            if (r_pend) begin
                r_red_index   <= w_red_next;
                r_blue_index  <= w_blue_next;
                r_rot_keycode <= '0;
                r_pend        <= 1'b0;
            end

            if (red_dead && blue_dead) begin
                r_state  <= ST_HALT;
                r_halted <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // A step due while one is in flight waits a cycle
                        if (w_dir_key && !r_pend) begin
                            r_rot_keycode <= keycode;
                            r_pend        <= 1'b1;
                            r_dir_cw      <= w_is_cw;
                            r_cnt         <= CNT_W'(REPEAT_DELAY - 1);
                            r_state       <= ST_HOLD;
                        end
                    end
                    ST_HOLD, ST_REPEAT: begin
                        if (!w_dir_key) begin
                            r_state <= ST_IDLE;
                        end else if (w_same_dir) begin
                            if (r_cnt != '0) begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end else if (!r_pend) begin
                                r_rot_keycode <= keycode;
                                r_pend        <= 1'b1;
                                r_cnt         <= CNT_W'(REPEAT_RATE - 1);
                                r_state       <= ST_REPEAT;
                            end
                        end else if (!r_pend) begin
                            // Reversal: step at once, restart the repeat delay
                            r_rot_keycode <= keycode;
                            r_pend        <= 1'b1;
                            r_dir_cw      <= w_is_cw;
                            r_cnt         <= CNT_W'(REPEAT_DELAY - 1);
                            r_state       <= ST_HOLD;
                        end
                    end
                    ST_HALT: begin
                        r_halted <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rot_keycode = r_rot_keycode;
    assign red_index   = r_red_index;
    assign blue_index  = r_blue_index;
    assign halted      = r_halted;

endmodule

// File: tb/tb_orbit_index_ctrl.sv
// Directed bench for orbit_index_ctrl: reset, tap, wrap/auto-repeat,
// reversal, halt and reset during an in-flight step.
module tb_orbit_index_ctrl;

    logic       frame_clk;
    logic       Reset;
    logic [7:0] keycode;
    logic       red_dead;
    logic       blue_dead;
    logic [7:0] rot_keycode;
    logic [5:0] red_index;
    logic [5:0] blue_index;
    logic       halted;

    int n_cmp;
    int n_err;

    orbit_index_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .red_dead    (red_dead),
        .blue_dead   (blue_dead),
        .rot_keycode (rot_keycode),
        .red_index   (red_index),
        .blue_index  (blue_index),
        .halted      (halted)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // One frame: inputs already set, wait for the edge, sample 1 ns later
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        Reset     = 1'b1;
        keycode   = 8'h07;
        red_dead  = 1'b0;
        blue_dead = 1'b0;

        // T1: reset wins over a held rotation key
        tick();
        chk("t1_red",    8'(red_index),  8'd0);
        chk("t1_blue",   8'(blue_index), 8'd30);
        chk("t1_rot",    rot_keycode,    8'h00);
        chk("t1_halted", 8'(halted),     8'd0);
        Reset   = 1'b0;
        keycode = 8'h00;
        tick();

        // T2: single CCW tap
        keycode = 8'h04;
        tick();
        chk("t2_rot_issue", rot_keycode,   8'h04);
        chk("t2_red_pre",   8'(red_index), 8'd0);
        keycode = 8'h00;
        tick();
        chk("t2_rot_clr",  rot_keycode,    8'h00);
        chk("t2_red_post", 8'(red_index),  8'd1);
        chk("t2_blue_post", 8'(blue_index), 8'd31);
        tick();

        // T3: CW held 20 frames from 0: steps at 0,8,10,...,18
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            keycode = 8'h07;
            tick();
            chk($sformatf("t3_rot_f%0d", i), rot_keycode,
                (i == 0 || (i >= 8 && (i % 2) == 0)) ? 8'h07 : 8'h00);
            if (i == 1) begin
                chk("t3_red_wrap",  8'(red_index),  8'd59);
                chk("t3_blue_wrap", 8'(blue_index), 8'd29);
            end
        end
        keycode = 8'h00;
        tick();
        chk("t3_rot_end",  rot_keycode,    8'h00);
        chk("t3_red_end",  8'(red_index),  8'd53);
        chk("t3_blue_end", 8'(blue_index), 8'd23);

        // T4: CCW 4 frames, then CW: immediate step, next one 8 frames later
        for (int i = 0; i < 13; i++) begin
            keycode = (i < 4) ? 8'h04 : 8'h07;
            tick();
            chk($sformatf("t4_rot_f%0d", i), rot_keycode,
                (i == 0) ? 8'h04 : ((i == 4 || i == 12) ? 8'h07 : 8'h00));
        end
        keycode = 8'h00;
        tick();
        chk("t4_red_end",  8'(red_index),  8'd52);
        chk("t4_blue_end", 8'(blue_index), 8'd22);

        // T5: one ball dead keeps rotating; both dead freezes everything
        red_dead = 1'b1;
        keycode  = 8'h04;
        tick();
        chk("t5_rot_one_dead", rot_keycode, 8'h04);
        keycode = 8'h00;
        tick();
        chk("t5_red_one_dead",  8'(red_index),  8'd53);
        chk("t5_blue_one_dead", 8'(blue_index), 8'd23);
        chk("t5_halted_one",    8'(halted),     8'd0);
        blue_dead = 1'b1;
        for (int i = 0; i < 100; i++) begin
            keycode = ((i % 2) == 0) ? 8'h04 : 8'h07;
            tick();
            chk($sformatf("t5_rot_f%0d", i), rot_keycode, 8'h00);
        end
        chk("t5_halted",     8'(halted),     8'd1);
        chk("t5_red_frozen", 8'(red_index),  8'd53);
        chk("t5_blue_frozen", 8'(blue_index), 8'd23);

        // T6: reset while a step is in flight discards the update
        red_dead  = 1'b0;
        blue_dead = 1'b0;
        keycode   = 8'h00;
        Reset     = 1'b1;
        tick();
        chk("t6_halted_clr", 8'(halted), 8'd0);
        Reset = 1'b0;
        tick();
        keycode = 8'h04;
        tick();
        chk("t6_rot_issue", rot_keycode, 8'h04);
        Reset   = 1'b1;
        keycode = 8'h00;
        tick();
        chk("t6_red_rst",  8'(red_index),  8'd0);
        chk("t6_blue_rst", 8'(blue_index), 8'd30);
        chk("t6_rot_rst",  rot_keycode,    8'h00);
        Reset = 1'b0;
        tick();
        chk("t6_red_late",  8'(red_index),  8'd0);
        chk("t6_blue_late", 8'(blue_index), 8'd30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
